frac_ce_cfg: RTL and testbench

Reconfiguration-bus responder that accepts the same management-write sequence our PLL reconfiguration initiator issues (mode at address 0, fractional K at address 7, start at address 2) and applies it to a 32-bit phase-accumulator clock enable instead of a hardware PLL. It sits on the `mgmt_clk` domain next to the initiator. It gives targets without a reconfigurable PLL the same native/60 Hz speed switch, with matching waitrequest and lock behaviour.

---
 rtl/frac_ce_cfg.sv | 196 +++++++++++++++++++
 tb/tb_frac_ce_cfg.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_ce_cfg.sv
// frac_ce_cfg: PLL-reconfiguration-compatible register responder driving a 32-bit phase-accumulator clock enable.
// Optional read path: define FRAC_CE_READBACK_EN to enable mgmt_readdata (tied to 0 otherwise).
module frac_ce_cfg #(
    parameter logic [31:0] K_RESET       = 32'hD8EC95C0,
    parameter int unsigned BUSY_CYCLES   = 4,
    parameter int unsigned RELOCK_CYCLES = 64
) (
    input  logic        mgmt_clk,
    input  logic        mgmt_reset,
    input  logic [5:0]  mgmt_address,
    input  logic        mgmt_write,
    input  logic [31:0] mgmt_writedata,
    input  logic        mgmt_read,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    output logic        ce_out,
    output logic        locked,
    output logic [31:0] active_k
);

    localparam logic [5:0]  ADDR_MODE   = 6'd0;
    localparam logic [5:0]  ADDR_STATUS = 6'd1;
    localparam logic [5:0]  ADDR_START  = 6'd2;
    localparam logic [5:0]  ADDR_ACTIVE = 6'd3;
    localparam logic [5:0]  ADDR_SHADOW = 6'd7;
    localparam logic [7:0]  BUSY_LOAD   = 8'(BUSY_CYCLES);
    localparam logic [15:0] RELOCK_LOAD = 16'(RELOCK_CYCLES);

    typedef enum logic [0:0] {
        ST_RELOCK = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_mode;
    logic [31:0] r_shadow;
    logic [31:0] r_active_k;
    logic [7:0]  r_busy_cnt;
    logic [15:0] r_relock_cnt;
    logic        r_waitrequest;
    logic        r_locked;
    logic [31:0] r_acc;
    logic        r_ce;

    state_t      w_state_nxt;
    logic        w_mode_nxt;
    logic [31:0] w_shadow_nxt;
    logic [31:0] w_active_nxt;
    logic [7:0]  w_busy_nxt;
    logic [15:0] w_relock_nxt;
    logic        w_wait_nxt;
    logic [31:0] w_acc_nxt;
    logic        w_ce_nxt;
    logic [32:0] w_sum;
    logic        w_wr_acc;
    logic        w_start;

    assign w_wr_acc = mgmt_write & ~r_waitrequest;
    assign w_start  = w_wr_acc & (mgmt_address == ADDR_START);
    assign w_sum    = {1'b0, r_acc} + {1'b0, r_active_k};

    // Register-file updates: mode/shadow land at the accepting edge, active K only on start.
    always_comb begin
        w_mode_nxt   = r_mode;
        w_shadow_nxt = r_shadow;
        w_active_nxt = r_active_k;
        if (w_wr_acc) begin
            case (mgmt_address)
                ADDR_MODE:   w_mode_nxt   = mgmt_writedata[0];
                ADDR_SHADOW: w_shadow_nxt = mgmt_writedata;
                ADDR_START:  w_active_nxt = r_shadow;
                default:     w_mode_nxt   = r_mode;
            endcase
        end else begin
            w_mode_nxt = r_mode;
        end
    end

    // Busy/relock counters and the waitrequest value they imply for the next cycle.
    always_comb begin
        if (w_wr_acc) begin
            w_busy_nxt = BUSY_LOAD;
        end else if (r_busy_cnt != 8'd0) begin
            w_busy_nxt = r_busy_cnt - 8'd1;
        end else begin
            w_busy_nxt = 8'd0;
        end
        if (w_start) begin
            w_relock_nxt = RELOCK_LOAD;
        end else if (r_relock_cnt != 16'd0) begin
            w_relock_nxt = r_relock_cnt - 16'd1;
        end else begin
            w_relock_nxt = 16'd0;
        end
        w_wait_nxt = (w_busy_nxt != 8'd0) | (~w_mode_nxt & (w_relock_nxt != 16'd0));
    end

    // Lock state and accumulator: a start forces RELOCK and clears the accumulator at once.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = 32'h0;
        w_ce_nxt    = 1'b0;
        if (w_start) begin
            w_state_nxt = ST_RELOCK;
        end else begin
            case (r_state)
                ST_RELOCK: begin
                    if (w_relock_nxt == 16'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_RELOCK;
                    end
                end
                ST_RUN: begin
                    w_state_nxt = ST_RUN;
                    w_acc_nxt   = w_sum[31:0];
                    w_ce_nxt    = w_sum[32];
                end
                default: begin
                    w_state_nxt = ST_RELOCK;
                end
            endcase
        end
    end

    // State register for control, configuration and accumulator.
    always_ff @(posedge mgmt_clk) begin
        if (mgmt_reset) begin
            r_state       <= ST_RELOCK;
            r_mode        <= 1'b0;
            r_shadow      <= K_RESET;
            r_active_k    <= K_RESET;
            r_busy_cnt    <= 8'd0;
            r_relock_cnt  <= RELOCK_LOAD;
            r_waitrequest <= 1'b1;
            r_locked      <= 1'b0;
            r_acc         <= 32'h0;
            r_ce          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_mode        <= w_mode_nxt;
            r_shadow      <= w_shadow_nxt;
            r_active_k    <= w_active_nxt;
            r_busy_cnt    <= w_busy_nxt;
            r_relock_cnt  <= w_relock_nxt;
            r_waitrequest <= w_wait_nxt;
            r_locked      <= (w_state_nxt == ST_RUN);
            r_acc         <= w_acc_nxt;
            r_ce          <= w_ce_nxt;
        end
    end

`ifdef FRAC_CE_READBACK_EN
    logic [31:0] r_readdata;
    logic [31:0] w_rdata_nxt;
    logic        w_rd_acc;

    // A simultaneous write wins, so the read is dropped and readdata holds.
    assign w_rd_acc = mgmt_read & ~r_waitrequest & ~mgmt_write;

    // Read mux, captured only on an accepted read.
    always_comb begin
        w_rdata_nxt = r_readdata;
        if (w_rd_acc) begin
            case (mgmt_address)
                ADDR_STATUS: w_rdata_nxt = {31'h0, ~r_locked};
                ADDR_ACTIVE: w_rdata_nxt = r_active_k;
                default:     w_rdata_nxt = 32'h0;
            endcase
        end else begin
            w_rdata_nxt = r_readdata;
        end
    end

    // Read data register.
    always_ff @(posedge mgmt_clk) begin
        if (mgmt_reset) begin
            r_readdata <= 32'h0;
        end else begin
            r_readdata <= w_rdata_nxt;
        end
    end

    assign mgmt_readdata = r_readdata;
`else
    logic w_unused_read;
    assign w_unused_read = mgmt_read;
    assign mgmt_readdata = 32'h0;
`endif

    assign mgmt_waitrequest = r_waitrequest;
    assign ce_out           = r_ce;
    assign locked           = r_locked;
    assign active_k         = r_active_k;

endmodule

// File: tb/tb_frac_ce_cfg.sv
// Self-checking bench for frac_ce_cfg: reset/relock timing, reconfiguration, polling, restart and read/write collision.
module tb_frac_ce_cfg;

    localparam logic [31:0] K_RESET = 32'hD8EC95C0;
    localparam int BUSY   = 4;
    localparam int RELOCK = 64;
`ifdef FRAC_CE_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic        mgmt_clk;
    logic        mgmt_reset;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        ce_out;
    logic        locked;
    logic [31:0] active_k;

    int checks   = 0;
    int failures = 0;
    int pcyc     = 0;
    int last_edge;
    int m_start_edge;
    logic        m_mode;
    logic [31:0] m_shadow;
    logic [31:0] m_active;
    logic [31:0] sb_q[$];
    logic        ce_q[$];

    frac_ce_cfg #(
        .K_RESET(K_RESET),
        .BUSY_CYCLES(BUSY),
        .RELOCK_CYCLES(RELOCK)
    ) dut (
        .mgmt_clk(mgmt_clk),
        .mgmt_reset(mgmt_reset),
        .mgmt_address(mgmt_address),
        .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata),
        .mgmt_read(mgmt_read),
        .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .ce_out(ce_out),
        .locked(locked),
        .active_k(active_k)
    );

    initial mgmt_clk = 1'b0;
    always #5 mgmt_clk = ~mgmt_clk;
    always @(posedge mgmt_clk) pcyc <= pcyc + 1;

    // Reference read value for a read accepted at posedge number e.
    function automatic logic [31:0] model_read(input logic [5:0] a, input int e);
        logic [31:0] v;
        case (a)
            6'd1:    v = {31'h0, ((e - 1) < (m_start_edge + RELOCK))};
            6'd3:    v = m_active;
            default: v = 32'h0;
        endcase
        if (!READBACK) v = 32'h0;
        return v;
    endfunction

    // Called at a negedge; holds the write until waitrequest is low, returns at the negedge after acceptance.
    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        int n;
        n = 0;
        mgmt_address = a; mgmt_writedata = d; mgmt_write = 1'b1;
        while (mgmt_waitrequest !== 1'b0 && n < 500) begin
            @(negedge mgmt_clk); n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL wr_timeout addr=%0d waited=%0d required<500", a, n);
        end
        last_edge = pcyc + 1;
        @(negedge mgmt_clk);
        mgmt_write = 1'b0;
        case (a)
            6'd0: m_mode = d[0];
            6'd7: m_shadow = d;
            6'd2: begin m_active = m_shadow; m_start_edge = last_edge; end
            default: m_mode = m_mode;
        endcase
    endtask

    // Called at a negedge; pushes the expected data to the scoreboard and returns the observed data.
    task automatic bus_read(input logic [5:0] a, output logic [31:0] obs);
        int n;
        n = 0;
        mgmt_address = a; mgmt_read = 1'b1;
        while (mgmt_waitrequest !== 1'b0 && n < 500) begin
            @(negedge mgmt_clk); n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL rd_timeout addr=%0d waited=%0d required<500", a, n);
        end
        sb_q.push_back(model_read(a, pcyc + 1));
        @(negedge mgmt_clk);
        mgmt_read = 1'b0;
        obs = mgmt_readdata;
    endtask

    // Counts wait-high and locked-low cycles from the current negedge until both settle.
    task automatic settle(output int nw, output int nl);
        int n;
        n = 0; nw = 0; nl = 0;
        while ((mgmt_waitrequest !== 1'b0 || locked !== 1'b1) && n < 400) begin
            if (mgmt_waitrequest !== 1'b0) nw++;
            if (locked !== 1'b1) nl++;
            @(negedge mgmt_clk); n++;
        end
    endtask

    // Runs the accumulator reference from the first locked negedge, counting ce mismatches and ones.
    task automatic run_ce(input logic [31:0] k, input int ncyc, output int mism, output int ones);
        logic [31:0] acc;
        logic [32:0] s;
        logic        expv;
        acc = 32'h0; mism = 0; ones = 0;
        ce_q.delete();
        ce_q.push_back(1'b0);
        for (int i = 0; i < ncyc; i++) begin
            expv = ce_q.pop_front();
            if (ce_out !== expv || locked !== 1'b1) mism++;
            if (ce_out === 1'b1) ones++;
            s = {1'b0, acc} + {1'b0, k};
            acc = s[31:0];
            ce_q.push_back(s[32]);
            @(negedge mgmt_clk);
        end
    endtask

    task automatic test_reset(input string tag);
        int n, bad, mism, ones, exp_ones;
        @(negedge mgmt_clk);
        mgmt_reset = 1'b1; mgmt_write = 1'b0; mgmt_read = 1'b0;
        repeat (3) @(negedge mgmt_clk);
        m_start_edge = pcyc; m_mode = 1'b0; m_shadow = K_RESET; m_active = K_RESET;
        checks += 5;
        if (mgmt_waitrequest !== 1'b1) begin failures++; $display("FAIL %s_rst_wait got=%b exp=1", tag, mgmt_waitrequest); end
        if (locked !== 1'b0) begin failures++; $display("FAIL %s_rst_locked got=%b exp=0", tag, locked); end
        if (ce_out !== 1'b0) begin failures++; $display("FAIL %s_rst_ce got=%b exp=0", tag, ce_out); end
        if (mgmt_readdata !== 32'h0) begin failures++; $display("FAIL %s_rst_rdata got=%h exp=0", tag, mgmt_readdata); end
        if (active_k !== K_RESET) begin failures++; $display("FAIL %s_rst_k got=%h exp=%h", tag, active_k, K_RESET); end
        mgmt_reset = 1'b0;
        n = 0; bad = 0;
        while (locked !== 1'b1 && n < RELOCK + 20) begin
            if (mgmt_waitrequest !== 1'b1) bad++;
            @(negedge mgmt_clk); n++;
        end
        checks += 3;
        if (n !== RELOCK) begin failures++; $display("FAIL %s_relock_len got=%0d exp=%0d", tag, n, RELOCK); end
        if (bad !== 0) begin failures++; $display("FAIL %s_wait_during_relock lowcycles=%0d exp=0", tag, bad); end
        if (mgmt_waitrequest !== 1'b0) begin failures++; $display("FAIL %s_wait_at_lock got=%b exp=0", tag, mgmt_waitrequest); end
        run_ce(K_RESET, 1000, mism, ones);
        exp_ones = int'((longint'({32'h0, K_RESET}) * 64'sd999) >>> 32);
        checks += 2;
        if (mism !== 0) begin failures++; $display("FAIL %s_ce_seq mismatches=%0d exp=0", tag, mism); end
        if (ones !== exp_ones) begin failures++; $display("FAIL %s_ce_avg ones=%0d exp=%0d", tag, ones, exp_ones); end
    endtask

    task automatic test_reconfig_waitmode();
        int nw, nl, mism, ones;
        bus_write(6'd0, 32'h0);
        settle(nw, nl);
        checks++;
        if (nw !== BUSY) begin failures++; $display("FAIL mode_busy got=%0d exp=%0d", nw, BUSY); end
        bus_write(6'd7, 32'hB11C6CC8);
        checks += 2;
        if (active_k !== K_RESET) begin failures++; $display("FAIL shadow_no_apply got=%h exp=%h", active_k, K_RESET); end
        settle(nw, nl);
        if (nw !== BUSY) begin failures++; $display("FAIL shadow_busy got=%0d exp=%0d", nw, BUSY); end
        bus_write(6'd2, 32'h0);
        checks += 4;
        if (active_k !== m_active) begin failures++; $display("FAIL start_k got=%h exp=%h", active_k, m_active); end
        settle(nw, nl);
        if (nw !== RELOCK) begin failures++; $display("FAIL start_wait_mode0 got=%0d exp=%0d", nw, RELOCK); end
        if (nl !== RELOCK) begin failures++; $display("FAIL start_relock got=%0d exp=%0d", nl, RELOCK); end
        run_ce(32'hB11C6CC8, 50, mism, ones);
        if (mism !== 0) begin failures++; $display("FAIL b11c_ce_seq mismatches=%0d exp=0", mism); end
    endtask

    task automatic test_half_rate();
        int nw, nl, mism, ones;
        bus_write(6'd7, 32'h80000000);
        settle(nw, nl);
        bus_write(6'd2, 32'h0);
        settle(nw, nl);
        run_ce(32'h80000000, 21, mism, ones);
        checks += 3;
        if (nl !== RELOCK) begin failures++; $display("FAIL half_relock got=%0d exp=%0d", nl, RELOCK); end
        if (mism !== 0) begin failures++; $display("FAIL half_ce_seq mismatches=%0d exp=0", mism); end
        if (ones !== 10) begin failures++; $display("FAIL half_ce_ones got=%0d exp=10", ones); end
    endtask

    task automatic test_poll_mode();
        int nw, n;
        logic [31:0] obs, expv;
        bus_write(6'd0, 32'h1);
        settle(nw, n);
        bus_write(6'd2, 32'h0);
        nw = 0;
        while (mgmt_waitrequest !== 1'b0 && nw < 300) begin @(negedge mgmt_clk); nw++; end
        checks += 2;
        if (nw !== BUSY) begin failures++; $display("FAIL poll_wait got=%0d exp=%0d", nw, BUSY); end
        if (locked !== 1'b0) begin failures++; $display("FAIL poll_locked got=%b exp=0", locked); end
        n = 0;
        expv = 32'h1;
        while (expv !== 32'h0 && n < 60) begin
            bus_read(6'd1, obs);
            expv = sb_q.pop_front();
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL poll_status n=%0d got=%h exp=%h", n, obs, expv); end
            n++;
        end
        bus_read(6'd3, obs);
        expv = sb_q.pop_front();
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL read_active got=%h exp=%h", obs, expv); end
        bus_read(6'd6, obs);
        expv = sb_q.pop_front();
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL read_other got=%h exp=%h", obs, expv); end
    endtask

    task automatic test_restart();
        int nw, nl, t1, mism, ones;
        settle(nw, nl);
        bus_write(6'd7, 32'h10000000);
        settle(nw, nl);
        bus_write(6'd2, 32'h0);
        t1 = last_edge;
        bus_write(6'd7, 32'h40000000);
        while (pcyc < t1 + 9) @(negedge mgmt_clk);
        bus_write(6'd2, 32'h0);
        checks += 5;
        if (active_k !== 32'h40000000) begin failures++; $display("FAIL restart_k got=%h exp=40000000", active_k); end
        if (locked !== 1'b0) begin failures++; $display("FAIL restart_locked got=%b exp=0", locked); end
        settle(nw, nl);
        if (nl !== RELOCK) begin failures++; $display("FAIL restart_relock got=%0d exp=%0d", nl, RELOCK); end
        if (nw !== BUSY) begin failures++; $display("FAIL restart_wait got=%0d exp=%0d", nw, BUSY); end
        run_ce(32'h40000000, 20, mism, ones);
        if (mism !== 0) begin failures++; $display("FAIL quarter_ce_seq mismatches=%0d exp=0", mism); end
    endtask

    task automatic test_rw_collision();
        int nw, nl;
        logic [31:0] obs, prev;
        bus_read(6'd3, obs);
        prev = sb_q.pop_front();
        checks++;
        if (obs !== prev) begin failures++; $display("FAIL pre_coll_read got=%h exp=%h", obs, prev); end
        nw = 0;
        while (mgmt_waitrequest !== 1'b0 && nw < 300) begin @(negedge mgmt_clk); nw++; end
        mgmt_address = 6'd7; mgmt_writedata = 32'h12345678; mgmt_write = 1'b1; mgmt_read = 1'b1;
        @(negedge mgmt_clk);
        mgmt_write = 1'b0; mgmt_read = 1'b0;
        m_shadow = 32'h12345678;
        checks += 3;
        if (mgmt_readdata !== prev) begin failures++; $display("FAIL coll_rdata got=%h exp=%h", mgmt_readdata, prev); end
        if (mgmt_waitrequest !== 1'b1) begin failures++; $display("FAIL coll_wait got=%b exp=1", mgmt_waitrequest); end
        settle(nw, nl);
        bus_write(6'd2, 32'h0);
        if (active_k !== 32'h12345678) begin failures++; $display("FAIL coll_write_applied got=%h exp=12345678", active_k); end
        settle(nw, nl);
    endtask

    initial begin
        mgmt_reset = 1'b1; mgmt_write = 1'b0; mgmt_read = 1'b0;
        mgmt_address = 6'd0; mgmt_writedata = 32'h0;
        test_reset("boot");
        test_reconfig_waitmode();
        test_half_rate();
        test_poll_mode();
        test_restart();
        test_rw_collision();
        test_reset("midop");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
